// File: rtl/instruction_fetch.sv
// instruction_fetch
//   Single-outstanding-read instruction fetch unit. It reads one word, holds
//   it for the decoder until accepted, then fetches the next sequential word.
//   Redirects reload the PC and abandon any held or in-flight instruction.
//   Watchdog and user request pulses are latched until the next acceptance.
//
// Ports
//   clock, reset                    clock, synchronous active-high reset
//   mem_addr, mem_read_en           instruction memory read request
//   mem_data, mem_ready             read data, valid for the outstanding read
//   redirect, redirect_target       PC load request (branch/jump/exception)
//   halt                            level request to stop issuing fetches
//   wd_irq, user_irq                single-cycle interrupt pulses
//   Instruction, instr_pc           held instruction word and its address
//   instr_valid, instr_ready        decoder handshake
//   wd_interruption, is_user_request pending flags, shown with instr_valid
module instruction_fetch #(
    parameter int INSTRUCTION_WIDTH = 16,
    parameter int ADDRESS_WIDTH = 16,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic [ADDRESS_WIDTH-1:0]     mem_addr,
    output logic                         mem_read_en,
    input  logic [INSTRUCTION_WIDTH-1:0] mem_data,
    input  logic                         mem_ready,
    input  logic                         redirect,
    input  logic [ADDRESS_WIDTH-1:0]     redirect_target,
    input  logic                         halt,
    input  logic                         wd_irq,
    input  logic                         user_irq,
    output logic [INSTRUCTION_WIDTH-1:0] Instruction,
    output logic [ADDRESS_WIDTH-1:0]     instr_pc,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic                         wd_interruption,
    output logic                         is_user_request
);

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, STOP} state_t;

    state_t                   state;
    logic [ADDRESS_WIDTH-1:0] pc;
    logic                     wd_pending;
    logic                     user_pending;
    logic                     accept;

    assign accept = instr_valid & instr_ready;

    // The read request is a decode of the registered state. It is masked by
    // reset so that no read leaves while reset is held, yet the first fetch
    // appears in the very first cycle after reset is released.
    assign mem_read_en     = (state == FETCH) & ~reset;
    assign mem_addr        = pc;
    assign wd_interruption = wd_pending & instr_valid;
    assign is_user_request = user_pending & instr_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= FETCH;
            pc           <= RESET_VECTOR;
            Instruction  <= '0;
            instr_pc     <= '0;
            instr_valid  <= 1'b0;
            wd_pending   <= 1'b0;
            user_pending <= 1'b0;
        end else begin
            // Acceptance clears the flags, but a pulse arriving in the same
            // cycle belongs to the next instruction and must survive.
            wd_pending   <= wd_irq   | (wd_pending   & ~accept);
            user_pending <= user_irq | (user_pending & ~accept);

            if (redirect) begin
                // Overrides every state: an in-flight read (even one
                // completing this cycle) is dropped and the held word is
                // withdrawn.
                pc          <= redirect_target;
                instr_valid <= 1'b0;
                state       <= FETCH;
            end else begin
                case (state)
                    FETCH: state <= WAIT;
                    WAIT: begin
                        if (mem_ready) begin
                            Instruction <= mem_data;
                            instr_pc    <= pc;
                            pc          <= pc + 1'b1;   // wraps naturally
                            instr_valid <= 1'b1;
                            state       <= HOLD;
                        end
                    end
                    HOLD: begin
                        if (accept) begin
                            instr_valid <= 1'b0;
                            state       <= halt ? STOP : FETCH;
                        end
                    end
                    STOP: begin
                        if (!halt) state <= FETCH;
                    end
                    default: state <= FETCH;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios followed by a
// randomized run checked against a transaction-level scoreboard.
module tb_instruction_fetch;

    localparam logic [15:0] RV = 16'h0000;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_read_en;
    logic [15:0] mem_data;
    logic        mem_ready;
    logic        redirect;
    logic [15:0] redirect_target;
    logic        halt;
    logic        wd_irq;
    logic        user_irq;
    logic [15:0] Instruction;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        wd_interruption;
    logic        is_user_request;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    instruction_fetch #(
        .INSTRUCTION_WIDTH(16),
        .ADDRESS_WIDTH(16),
        .RESET_VECTOR(RV)
    ) dut (
        .clock(clock), .reset(reset),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_data(mem_data), .mem_ready(mem_ready),
        .redirect(redirect), .redirect_target(redirect_target),
        .halt(halt), .wd_irq(wd_irq), .user_irq(user_irq),
        .Instruction(Instruction), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .wd_interruption(wd_interruption), .is_user_request(is_user_request)
    );

    // Memory contents: fixed words at 0 and 1, a hash everywhere else.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (a == 16'h0000) return 16'h2105;
        if (a == 16'h0001) return 16'h1888;
        return 16'(a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    // Memory: one outstanding read; a new request replaces an old one.
    // Latency 0 means data is ready in the cycle after the request.
    int          mem_lat = 0;
    int          mcnt    = 0;
    logic        mpend   = 1'b0;
    logic [15:0] maddr   = 16'h0;

    always @(posedge clock) begin
        if (mem_read_en) begin
            mpend <= 1'b1;
            maddr <= mem_addr;
            mcnt  <= mem_lat;
        end else if (mpend) begin
            if (mcnt == 0) mpend <= 1'b0;
            else           mcnt  <= mcnt - 1;
        end
    end

    assign mem_ready = mpend && (mcnt == 0);
    assign mem_data  = mem_word(maddr);

    // Advance to the sampling point of the next cycle.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Leaves the bench in the first post-reset cycle (the FETCH cycle).
    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0; halt = 1'b0; wd_irq = 1'b0; user_irq = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b1; redirect_target = 16'h4444; halt = 1'b1;
        wd_irq = 1'b1; user_irq = 1'b1; instr_ready = 1'b0;
        step();
        step();
        n_cmp++; if (mem_read_en !== 1'b0) begin n_mis++; $display("FAIL reset_rd_en: got %b want 0", mem_read_en); end
        n_cmp++; if (instr_valid !== 1'b0) begin n_mis++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_cmp++; if (Instruction !== 16'h0 || instr_pc !== 16'h0) begin n_mis++; $display("FAIL reset_regs: got %h/%h want 0/0", Instruction, instr_pc); end
        n_cmp++; if ({wd_interruption, is_user_request} !== 2'b00) begin n_mis++; $display("FAIL reset_flags: got %b want 00", {wd_interruption, is_user_request}); end
        redirect = 1'b0; halt = 1'b0; wd_irq = 1'b0; user_irq = 1'b0; reset = 1'b0;
        #1;
        n_cmp++; if (mem_read_en !== 1'b1 || mem_addr !== RV) begin n_mis++; $display("FAIL reset_first_fetch: got %b/%h want 1/%h", mem_read_en, mem_addr, RV); end
    endtask

    task automatic test_basic();
        mem_lat = 0; instr_ready = 1'b1;
        do_reset();
        n_cmp++; if (mem_read_en !== 1'b1 || mem_addr !== 16'h0000) begin n_mis++; $display("FAIL basic_fetch0: got %b/%h want 1/0000", mem_read_en, mem_addr); end
        step();
        n_cmp++; if (mem_read_en !== 1'b0 || instr_valid !== 1'b0) begin n_mis++; $display("FAIL basic_wait: rd %b valid %b want 0/0", mem_read_en, instr_valid); end
        step();
        n_cmp++; if (instr_valid !== 1'b1 || Instruction !== 16'h2105 || instr_pc !== 16'h0000) begin n_mis++; $display("FAIL basic_instr0: got %b %h @%h want 1 2105 @0000", instr_valid, Instruction, instr_pc); end
        step();
        n_cmp++; if (mem_read_en !== 1'b1 || mem_addr !== 16'h0001) begin n_mis++; $display("FAIL basic_fetch1: got %b/%h want 1/0001", mem_read_en, mem_addr); end
        step();
        step();
        n_cmp++; if (instr_valid !== 1'b1 || Instruction !== 16'h1888 || instr_pc !== 16'h0001) begin n_mis++; $display("FAIL basic_instr1: got %b %h @%h want 1 1888 @0001", instr_valid, Instruction, instr_pc); end
    endtask

    task automatic test_hold();
        logic [15:0] ri, rp;
        mem_lat = 0; instr_ready = 1'b0;
        do_reset();
        step();
        step();
        ri = Instruction; rp = instr_pc;
        n_cmp++; if (instr_valid !== 1'b1 || rp !== RV) begin n_mis++; $display("FAIL hold_enter: valid %b pc %h want 1 %h", instr_valid, rp, RV); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++; if (instr_valid !== 1'b1 || Instruction !== ri || instr_pc !== rp || mem_read_en !== 1'b0)
                begin n_mis++; $display("FAIL hold_stable: v %b %h @%h rd %b want 1 %h @%h rd 0", instr_valid, Instruction, instr_pc, mem_read_en, ri, rp); end
        end
        instr_ready = 1'b1;
        step();
        n_cmp++; if (mem_read_en !== 1'b1 || mem_addr !== 16'(rp + 1)) begin n_mis++; $display("FAIL hold_next: got %b/%h want 1/%h", mem_read_en, mem_addr, 16'(rp + 1)); end
    endtask

    task automatic test_redirect();
        mem_lat = 0; instr_ready = 1'b1;
        do_reset();
        step();
        redirect = 1'b1; redirect_target = 16'h0800;   // WAIT cycle, mem_ready high
        step();
        redirect = 1'b0;
        n_cmp++; if (instr_valid !== 1'b0 || mem_read_en !== 1'b1 || mem_addr !== 16'h0800) begin n_mis++; $display("FAIL redir_fetch: v %b rd %b addr %h want 0 1 0800", instr_valid, mem_read_en, mem_addr); end
        step();
        n_cmp++; if (instr_valid !== 1'b0) begin n_mis++; $display("FAIL redir_no_stale: valid %b want 0", instr_valid); end
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'h0800 || Instruction !== mem_word(16'h0800))
            begin n_mis++; $display("FAIL redir_instr: v %b %h @%h want 1 %h @0800", instr_valid, Instruction, instr_pc, mem_word(16'h0800)); end
    endtask

    task automatic test_irq();
        mem_lat = 0; instr_ready = 1'b0;
        do_reset();
        user_irq = 1'b1;             // FETCH
        step();
        user_irq = 1'b0; wd_irq = 1'b1;   // WAIT
        step();
        wd_irq = 1'b0;
        n_cmp++; if (instr_valid !== 1'b1 || wd_interruption !== 1'b1 || is_user_request !== 1'b1)
            begin n_mis++; $display("FAIL irq_first: v %b wd %b usr %b want 1 1 1", instr_valid, wd_interruption, is_user_request); end
        instr_ready = 1'b1; wd_irq = 1'b1;   // second pulse in acceptance cycle
        step();
        wd_irq = 1'b0; instr_ready = 1'b0;
        n_cmp++; if ({instr_valid, wd_interruption, is_user_request} !== 3'b000) begin n_mis++; $display("FAIL irq_gated: got %b want 000", {instr_valid, wd_interruption, is_user_request}); end
        step();
        step();
        n_cmp++; if (instr_valid !== 1'b1 || wd_interruption !== 1'b1 || is_user_request !== 1'b0)
            begin n_mis++; $display("FAIL irq_second: v %b wd %b usr %b want 1 1 0", instr_valid, wd_interruption, is_user_request); end
        instr_ready = 1'b1;
        step();
        step();
        step();
        n_cmp++; if (instr_valid !== 1'b1 || wd_interruption !== 1'b0) begin n_mis++; $display("FAIL irq_cleared: v %b wd %b want 1 0", instr_valid, wd_interruption); end
    endtask

    task automatic test_wrap_halt();
        mem_lat = 0; instr_ready = 1'b1;
        do_reset();
        redirect = 1'b1; redirect_target = 16'hFFFF;
        step();
        redirect = 1'b0;
        n_cmp++; if (mem_read_en !== 1'b1 || mem_addr !== 16'hFFFF) begin n_mis++; $display("FAIL wrap_fetch: got %b/%h want 1/ffff", mem_read_en, mem_addr); end
        step();
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF) begin n_mis++; $display("FAIL wrap_instr: v %b @%h want 1 @ffff", instr_valid, instr_pc); end
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++; if (mem_read_en !== 1'b0 || instr_valid !== 1'b0) begin n_mis++; $display("FAIL halt_stop: rd %b v %b want 0 0", mem_read_en, instr_valid); end
        end
        halt = 1'b0;
        step();
        n_cmp++; if (mem_read_en !== 1'b1 || mem_addr !== 16'h0000) begin n_mis++; $display("FAIL wrap_resume: got %b/%h want 1/0000", mem_read_en, mem_addr); end
    endtask

    task automatic test_reset_wait();
        mem_lat = 0; instr_ready = 1'b0;
        do_reset();
        redirect = 1'b1; redirect_target = 16'h1234;
        step();
        redirect = 1'b0; wd_irq = 1'b1;   // FETCH of 1234
        step();
        wd_irq = 1'b0;                    // WAIT with read completing
        reset = 1'b1;
        step();
        n_cmp++; if ({instr_valid, mem_read_en, wd_interruption, is_user_request} !== 4'b0000)
            begin n_mis++; $display("FAIL rstwait_state: got %b want 0000", {instr_valid, mem_read_en, wd_interruption, is_user_request}); end
        reset = 1'b0;
        #1;
        n_cmp++; if (mem_read_en !== 1'b1 || mem_addr !== RV) begin n_mis++; $display("FAIL rstwait_fetch: got %b/%h want 1/%h", mem_read_en, mem_addr, RV); end
        step();
        step();
        n_cmp++; if (instr_valid !== 1'b1 || instr_pc !== RV || wd_interruption !== 1'b0)
            begin n_mis++; $display("FAIL rstwait_instr: v %b @%h wd %b want 1 @%h 0", instr_valid, instr_pc, wd_interruption, RV); end
    endtask

    // Randomized traffic against a scoreboard that tracks only what the
    // rules promise: which address must be read next, which read a delivered
    // word belongs to, when the held word must stay put or disappear, and
    // which flags are pending.
    task automatic test_random();
        logic [15:0] mpc, inf_addr, p_instr, p_pc;
        bit inflight, stopped, m_wd, m_us, p_valid, e_fetch, e_inv, e_same, acc;
        mem_lat = 0; instr_ready = 1'b1;
        do_reset();
        mpc = RV; inf_addr = 16'h0; p_instr = 16'h0; p_pc = 16'h0;
        inflight = 0; stopped = 0; m_wd = 0; m_us = 0; p_valid = 0;
        e_fetch = 1; e_inv = 1; e_same = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c != 0) step();
            if (e_fetch) begin
                n_cmp++; if (mem_read_en !== 1'b1) begin n_mis++; $display("FAIL rnd_fetch_due c%0d: rd %b want 1", c, mem_read_en); end
            end
            if (stopped) begin
                n_cmp++; if (mem_read_en !== 1'b0) begin n_mis++; $display("FAIL rnd_halted_read c%0d: rd %b want 0", c, mem_read_en); end
            end
            if (mem_read_en) begin
                n_cmp++; if (mem_addr !== mpc || instr_valid !== 1'b0) begin n_mis++; $display("FAIL rnd_read c%0d: addr %h v %b want %h 0", c, mem_addr, instr_valid, mpc); end
                inflight = 1; inf_addr = mem_addr;
            end
            if (e_inv) begin
                n_cmp++; if (instr_valid !== 1'b0) begin n_mis++; $display("FAIL rnd_drop c%0d: valid %b want 0", c, instr_valid); end
            end
            if (e_same) begin
                n_cmp++; if (instr_valid !== 1'b1 || Instruction !== p_instr || instr_pc !== p_pc)
                    begin n_mis++; $display("FAIL rnd_hold c%0d: v %b %h @%h want 1 %h @%h", c, instr_valid, Instruction, instr_pc, p_instr, p_pc); end
            end
            if (instr_valid && !p_valid) begin
                n_cmp++; if (!inflight || instr_pc !== inf_addr || Instruction !== mem_word(inf_addr))
                    begin n_mis++; $display("FAIL rnd_deliver c%0d: %h @%h inflight %b want %h @%h", c, Instruction, instr_pc, inflight, mem_word(inf_addr), inf_addr); end
                mpc = 16'(inf_addr + 1);
                inflight = 0;
            end
            n_cmp++; if (wd_interruption !== (instr_valid & m_wd) || is_user_request !== (instr_valid & m_us))
                begin n_mis++; $display("FAIL rnd_flags c%0d: wd %b usr %b want %b %b", c, wd_interruption, is_user_request, instr_valid & m_wd, instr_valid & m_us); end

            // inputs for the coming edge
            redirect        = ($urandom_range(24) == 0);
            redirect_target = ($urandom_range(3) == 0) ? 16'hFFFF : 16'($urandom);
            if ($urandom_range(7) == 0) halt = ~halt;
            wd_irq          = ($urandom_range(9) == 0);
            user_irq        = ($urandom_range(9) == 0);
            instr_ready     = ($urandom_range(2) != 0);
            mem_lat         = $urandom_range(2);

            // scoreboard update for the coming edge
            acc     = instr_valid && instr_ready;
            m_wd    = wd_irq   | (m_wd & !acc);
            m_us    = user_irq | (m_us & !acc);
            e_fetch = 0; e_inv = 0; e_same = 0;
            if (redirect) begin
                mpc = redirect_target; inflight = 0; stopped = 0; e_inv = 1; e_fetch = 1;
            end else if (acc) begin
                e_inv = 1;
                if (halt) stopped = 1; else e_fetch = 1;
            end else if (instr_valid) begin
                e_same = 1;
            end else if (stopped && !halt) begin
                stopped = 0; e_fetch = 1;
            end
            p_valid = instr_valid; p_instr = Instruction; p_pc = instr_pc;
        end
        redirect = 1'b0; halt = 1'b0; wd_irq = 1'b0; user_irq = 1'b0;
    endtask

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_target = 16'h0; halt = 1'b0;
        wd_irq = 1'b0; user_irq = 1'b0; instr_ready = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_redirect();
        test_irq();
        test_wrap_halt();
        test_reset_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 16, giving the instruction word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 16, giving the word-address width.
REQ-003 SHALL have parameter RESET_VECTOR, default 0, giving the first fetch address after reset.
REQ-004 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 SHALL have port mem_addr, output, ADDRESS_WIDTH, the instruction memory read address.
REQ-007 SHALL have port mem_read_en, output, 1, the memory read request.
REQ-008 SHALL have port mem_data, input, INSTRUCTION_WIDTH, the memory read data.
REQ-009 SHALL have port mem_ready, input, 1, marking mem_data valid for the outstanding read.
REQ-010 SHALL have port redirect, input, 1, the branch/jump/exception PC load request.
REQ-011 SHALL have port redirect_target, input, ADDRESS_WIDTH, the new fetch address.
REQ-012 SHALL have port halt, input, 1, the level request to stop issuing fetches.
REQ-013 SHALL have port wd_irq, input, 1, a single-cycle watchdog interrupt pulse.
REQ-014 SHALL have port user_irq, input, 1, a single-cycle user/IO request pulse.
REQ-015 SHALL have port Instruction, output, INSTRUCTION_WIDTH, the held instruction for the decoder.
REQ-016 SHALL have port instr_pc, output, ADDRESS_WIDTH, the address of the held Instruction.
REQ-017 SHALL have port instr_valid, output, 1, asserted when Instruction/instr_pc are valid.
REQ-018 SHALL have port instr_ready, input, 1, the consumer accept signal.
REQ-019 SHALL have port wd_interruption, output, 1, the latched watchdog flag sent to the decoder.
REQ-020 SHALL have port is_user_request, output, 1, the latched user-request flag sent to the decoder.

Function
REQ-021 SHALL implement FSM states FETCH, WAIT, HOLD and STOP.
REQ-022 FETCH: SHALL drive mem_read_en=1 and mem_addr=pc, then go to WAIT next cycle.
REQ-023 WAIT: SHALL keep mem_read_en=0; on mem_ready SHALL capture Instruction=mem_data and instr_pc=pc, set pc=pc+1, and go to HOLD.
REQ-024 HOLD: SHALL assert instr_valid and keep Instruction/instr_pc stable until the cycle instr_valid&&instr_ready (acceptance).
REQ-025 On acceptance, SHALL go to STOP if halt=1, else to FETCH; one-instruction minimum latency: FETCH->WAIT->HOLD = 2 cycles with zero-wait memory.
REQ-026 STOP: SHALL issue no reads and SHALL return to FETCH the first cycle halt=0.
REQ-027 pc+1 SHALL wrap modulo 2^ADDRESS_WIDTH, so all-ones wraps to 0.
REQ-028 redirect in any state SHALL load pc=redirect_target, deassert instr_valid, and go to FETCH next cycle; redirect has priority over halt.
REQ-029 redirect in WAIT SHALL discard the in-flight read, including mem_ready in the same cycle; no stale instruction shall ever reach HOLD.
REQ-030 redirect in the same cycle as acceptance SHALL complete the acceptance (flags clear) and then follow REQ-028.
REQ-031 wd_irq / user_irq pulses SHALL set sticky pending flags, independently and in any state.
REQ-032 wd_interruption / is_user_request outputs SHALL equal the pending flags, gated by instr_valid.
REQ-033 Both pending flags SHALL clear on acceptance; a pulse arriving in the acceptance cycle SHALL remain pending.
REQ-034 instr_valid SHALL never deassert without acceptance, redirect or reset.

Reset
REQ-035 When reset=1 at a rising edge, the block SHALL set state=FETCH, pc=RESET_VECTOR, Instruction=0, instr_pc=0, instr_valid=0, flags=0, and mem_read_en=0 during reset.
REQ-036 Reset SHALL override redirect, halt and interrupts, discard any in-flight read, and produce the first fetch on the cycle after reset deasserts.

Verification
REQ-037 Reset release, memory 0->16'h2105, 1->16'h1888, zero-wait, instr_ready=1 -> mem_addr 0 then 1; Instruction 16'h2105/instr_pc 0 valid cycle 2, then 16'h1888/instr_pc 1.
REQ-038 instr_ready=0 for 5 cycles in HOLD -> Instruction/instr_pc stable, no reads issued; accept -> next read at pc+1.
REQ-039 redirect target 16'h0800 in WAIT with mem_ready same cycle -> data dropped, next mem_addr=16'h0800, no instr_valid before that read returns.
REQ-040 wd_irq pulse during WAIT -> wd_interruption=1 with the next instruction, cleared after acceptance; second pulse in the acceptance cycle -> set on the following instruction.
REQ-041 pc=16'hFFFF fetched -> next mem_addr=16'h0000; halt=1 at acceptance -> no reads until halt=0, then resume at pc.
REQ-042 reset asserted in WAIT with mem_ready pending -> instr_valid=0, flags 0, first post-reset mem_addr=RESET_VECTOR.
